// File: rtl/router_pkg.sv
// Shared router types: port identifiers and the switch-allocator output FSM states.
package router_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int PORT_W       = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL     = 3'd0,
        NORTH     = 3'd1,
        EAST      = 3'd2,
        SOUTH     = 3'd3,
        WEST      = 3'd4,
        NONE_PORT = 3'd5
    } PORT_t;

    typedef enum logic {
        SA_FREE,
        SA_LOCKED
    } SA_STATE_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grantIdx,
    output logic         o_valid
);

    int w_cand;

    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        o_valid    = 1'b0;
        w_cand     = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grantIdx      = W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocation: per-output round-robin grant, held locked to the
// winning input until its packet completes; drives crossbar selects.
module switch_allocator
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_OF_PORTS,
    parameter int SEL_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS*PORT_W-1:0]   i_req_port,
    input  logic [NUM_PORTS-1:0]          i_packet_done,
    output logic [NUM_PORTS-1:0]          o_ack,
    output logic [NUM_PORTS*SEL_BITS-1:0] o_xbar_sel,
    output logic [NUM_PORTS-1:0]          o_xbar_valid
);

    SA_STATE_t             r_state   [NUM_PORTS];
    logic [SEL_BITS-1:0]   r_owner   [NUM_PORTS];
    logic [SEL_BITS-1:0]   r_rrPtr   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_ack;

    SA_STATE_t             w_stateNext [NUM_PORTS];
    logic [SEL_BITS-1:0]   w_ownerNext [NUM_PORTS];
    logic [SEL_BITS-1:0]   w_ptrNext   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_ownsAny;
    logic [NUM_PORTS-1:0]  w_reqVec    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_gntOneHot [NUM_PORTS];
    logic [SEL_BITS-1:0]   w_gntIdx    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_gntValid;
    logic [NUM_PORTS-1:0]  w_ackNext;

    // An input holding any output may not compete for another one.
    always_comb begin
        w_ownsAny = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_state[o] == SA_LOCKED && r_owner[o] == SEL_BITS'(i)) begin
                    w_ownsAny[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_reqVec[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_reqVec[o][i] = i_req[i] && !w_ownsAny[i]
                              && (i_req_port[i*PORT_W +: PORT_W] == PORT_W'(o))
                              && (r_state[o] == SA_FREE);
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        rr_arbiter #(
            .N (NUM_PORTS),
            .W (SEL_BITS)
        ) u_rr_arbiter (
            .i_req      (w_reqVec[g]),
            .i_ptr      (r_rrPtr[g]),
            .o_grant    (w_gntOneHot[g]),
            .o_grantIdx (w_gntIdx[g]),
            .o_valid    (w_gntValid[g])
        );
    end

    // Release and grant are mutually exclusive within a cycle: a LOCKED output
    // only looks at its owner's done, so a re-grant is evaluated one cycle later.
    always_comb begin
        w_ackNext = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_stateNext[o] = r_state[o];
            w_ownerNext[o] = r_owner[o];
            w_ptrNext[o]   = r_rrPtr[o];
            case (r_state[o])
                SA_FREE: begin
                    if (w_gntValid[o]) begin
                        w_stateNext[o] = SA_LOCKED;
                        w_ownerNext[o] = w_gntIdx[o];
                        w_ptrNext[o]   = (w_gntIdx[o] == SEL_BITS'(NUM_PORTS - 1))
                                         ? '0 : w_gntIdx[o] + 1'b1;
                        w_ackNext      = w_ackNext | w_gntOneHot[o];
                    end
                end
                SA_LOCKED: begin
                    if (i_packet_done[r_owner[o]]) begin
                        w_stateNext[o] = SA_FREE;
                    end
                end
                default: w_stateNext[o] = SA_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o] <= SA_FREE;
                r_owner[o] <= '0;
                r_rrPtr[o] <= '0;
            end
        end else begin
            r_ack <= w_ackNext;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o] <= w_stateNext[o];
                r_owner[o] <= w_ownerNext[o];
                r_rrPtr[o] <= w_ptrNext[o];
            end
        end
    end

    always_comb begin
        o_ack        = r_ack;
        o_xbar_sel   = '0;
        o_xbar_valid = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            o_xbar_sel[o*SEL_BITS +: SEL_BITS] = r_owner[o];
            o_xbar_valid[o]                    = (r_state[o] == SA_LOCKED);
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized
// requester agents checked against a behavioural allocation model.
module tb_switch_allocator;
    import router_pkg::*;

    localparam int NP = 5;
    localparam int SB = 3;

    logic            clk;
    logic            reset;
    logic [NP-1:0]   i_req;
    logic [NP*3-1:0] i_req_port;
    logic [NP-1:0]   i_packet_done;
    logic [NP-1:0]   o_ack;
    logic [NP*SB-1:0] o_xbar_sel;
    logic [NP-1:0]   o_xbar_valid;

    int nChecks = 0;
    int nPass   = 0;

    bit          mLocked [NP];
    int          mOwner  [NP];
    int          mPtr    [NP];
    logic [NP-1:0] mAck;

    switch_allocator dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_req_port    (i_req_port),
        .i_packet_done (i_packet_done),
        .o_ack         (o_ack),
        .o_xbar_sel    (o_xbar_sel),
        .o_xbar_valid  (o_xbar_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Allocation rules evaluated from the current inputs and the model's lock table.
    function automatic void modelStep();
        bit owns [NP];
        int cand;
        mAck = '0;
        if (reset) begin
            for (int o = 0; o < NP; o++) begin
                mLocked[o] = 0;
                mOwner[o]  = 0;
                mPtr[o]    = 0;
            end
            return;
        end
        for (int i = 0; i < NP; i++) owns[i] = 0;
        for (int o = 0; o < NP; o++) if (mLocked[o]) owns[mOwner[o]] = 1;
        for (int o = 0; o < NP; o++) begin
            if (mLocked[o]) begin
                if (i_packet_done[mOwner[o]]) mLocked[o] = 0;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    cand = (mPtr[o] + k) % NP;
                    if (i_req[cand] && !owns[cand] && int'(i_req_port[cand*3 +: 3]) == o) begin
                        mLocked[o]  = 1;
                        mOwner[o]   = cand;
                        mPtr[o]     = (cand + 1) % NP;
                        mAck[cand]  = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic logic [NP-1:0] expValid();
        logic [NP-1:0] v;
        for (int o = 0; o < NP; o++) v[o] = mLocked[o];
        return v;
    endfunction

    function automatic logic [NP*SB-1:0] expSel();
        logic [NP*SB-1:0] s;
        for (int o = 0; o < NP; o++) s[o*SB +: SB] = SB'(mOwner[o]);
        return s;
    endfunction

    function automatic logic [SB-1:0] selOf(input int o);
        return o_xbar_sel[o*SB +: SB];
    endfunction

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        i_req         = '0;
        i_req_port    = {NP{3'd5}};
        i_packet_done = '0;
    endtask

    task automatic setReq(input int i, input int p);
        i_req[i]            = 1'b1;
        i_req_port[i*3 +: 3] = 3'(p);
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (o_ack !== 5'b0) $display("[TB] FAIL reset_ack: got %b want %b", o_ack, 5'b0);
        else nPass++;
        nChecks++;
        if (o_xbar_valid !== 5'b0) $display("[TB] FAIL reset_valid: got %b want %b", o_xbar_valid, 5'b0);
        else nPass++;
        nChecks++;
        if (o_xbar_sel !== 15'b0) $display("[TB] FAIL reset_sel: got %h want %h", o_xbar_sel, 15'b0);
        else nPass++;
    endtask

    task automatic test_single();
        doReset();
        setReq(int'(LOCAL), int'(EAST));
        tick();
        nChecks++;
        if (o_ack !== 5'b00001) $display("[TB] FAIL single_ack: got %b want %b", o_ack, 5'b00001);
        else nPass++;
        nChecks++;
        if ({o_xbar_valid, selOf(int'(EAST))} !== {5'b00100, 3'd0})
            $display("[TB] FAIL single_path: got valid=%b sel=%0d want valid=00100 sel=0", o_xbar_valid, selOf(int'(EAST)));
        else nPass++;
        i_req = '0;
        tick();
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b0, 5'b00100})
            $display("[TB] FAIL single_hold: got ack=%b valid=%b want ack=00000 valid=00100", o_ack, o_xbar_valid);
        else nPass++;
        i_packet_done[int'(LOCAL)] = 1'b1;
        tick();
        i_packet_done = '0;
        nChecks++;
        if (o_xbar_valid !== 5'b0) $display("[TB] FAIL single_release: got %b want %b", o_xbar_valid, 5'b0);
        else nPass++;
    endtask

    task automatic test_contention();
        doReset();
        setReq(int'(NORTH), int'(WEST));
        setReq(int'(SOUTH), int'(WEST));
        tick();
        nChecks++;
        if ({o_ack, selOf(int'(WEST))} !== {5'b00010, 3'd1})
            $display("[TB] FAIL rr_first: got ack=%b sel=%0d want ack=00010 sel=1", o_ack, selOf(int'(WEST)));
        else nPass++;
        i_req[int'(NORTH)] = 1'b0;
        tick();
        tick();
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b0, 5'b10000})
            $display("[TB] FAIL rr_locked: got ack=%b valid=%b want ack=00000 valid=10000", o_ack, o_xbar_valid);
        else nPass++;
        i_packet_done[int'(NORTH)] = 1'b1;
        tick();
        i_packet_done = '0;
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b0, 5'b0})
            $display("[TB] FAIL rr_release: got ack=%b valid=%b want ack=00000 valid=00000", o_ack, o_xbar_valid);
        else nPass++;
        tick();
        nChecks++;
        if ({o_ack, selOf(int'(WEST))} !== {5'b01000, 3'd3})
            $display("[TB] FAIL rr_second: got ack=%b sel=%0d want ack=01000 sel=3", o_ack, selOf(int'(WEST)));
        else nPass++;
        i_req[int'(SOUTH)] = 1'b0;
        tick();
        i_packet_done[int'(SOUTH)] = 1'b1;
        tick();
        i_packet_done = '0;
        setReq(int'(NORTH), int'(WEST));
        setReq(int'(SOUTH), int'(WEST));
        tick();
        nChecks++;
        if (o_ack !== 5'b00010) $display("[TB] FAIL rr_repeat: got %b want %b", o_ack, 5'b00010);
        else nPass++;
        clearInputs();
    endtask

    task automatic test_lock_hold_wrap();
        doReset();
        setReq(int'(LOCAL), int'(EAST));
        tick();
        i_req = '0;
        setReq(int'(WEST), int'(EAST));
        for (int c = 0; c < 10; c++) begin
            tick();
            nChecks++;
            if ({o_ack, selOf(int'(EAST))} !== {5'b0, 3'd0})
                $display("[TB] FAIL hold_cycle%0d: got ack=%b sel=%0d want ack=00000 sel=0", c, o_ack, selOf(int'(EAST)));
            else nPass++;
        end
        i_packet_done[int'(LOCAL)] = 1'b1;
        tick();
        i_packet_done = '0;
        nChecks++;
        if (o_ack !== 5'b0) $display("[TB] FAIL hold_no_same_cycle: got %b want %b", o_ack, 5'b0);
        else nPass++;
        tick();
        nChecks++;
        if ({o_ack, selOf(int'(EAST))} !== {5'b10000, 3'd4})
            $display("[TB] FAIL hold_regrant: got ack=%b sel=%0d want ack=10000 sel=4", o_ack, selOf(int'(EAST)));
        else nPass++;
        i_req = '0;
        i_packet_done[int'(WEST)] = 1'b1;
        tick();
        i_packet_done = '0;
        setReq(int'(LOCAL), int'(EAST));
        setReq(int'(WEST), int'(EAST));
        tick();
        nChecks++;
        if (o_ack !== 5'b00001) $display("[TB] FAIL wrap_ptr: got %b want %b", o_ack, 5'b00001);
        else nPass++;
        clearInputs();
    endtask

    task automatic test_parallel_ignore();
        doReset();
        setReq(int'(NORTH), int'(EAST));
        setReq(int'(SOUTH), int'(LOCAL));
        tick();
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b01010, 5'b00101})
            $display("[TB] FAIL parallel: got ack=%b valid=%b want ack=01010 valid=00101", o_ack, o_xbar_valid);
        else nPass++;
        i_req = '0;
        setReq(int'(WEST), int'(NONE_PORT));
        tick();
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b0, 5'b00101})
            $display("[TB] FAIL none_port: got ack=%b valid=%b want ack=00000 valid=00101", o_ack, o_xbar_valid);
        else nPass++;
        setReq(int'(WEST), 7);
        setReq(int'(NORTH), int'(SOUTH));
        tick();
        nChecks++;
        if ({o_ack, o_xbar_valid} !== {5'b0, 5'b00101})
            $display("[TB] FAIL bad_port_or_owner_req: got ack=%b valid=%b want ack=00000 valid=00101", o_ack, o_xbar_valid);
        else nPass++;
        i_req = '0;
        i_packet_done[int'(WEST)]  = 1'b1;
        i_packet_done[int'(LOCAL)] = 1'b1;
        tick();
        i_packet_done = '0;
        nChecks++;
        if ({o_xbar_valid, selOf(int'(EAST)), selOf(int'(LOCAL))} !== {5'b00101, 3'd1, 3'd3})
            $display("[TB] FAIL foreign_done: got valid=%b selE=%0d selL=%0d want valid=00101 selE=1 selL=3",
                     o_xbar_valid, selOf(int'(EAST)), selOf(int'(LOCAL)));
        else nPass++;
        clearInputs();
    endtask

    task automatic test_reset_mid();
        doReset();
        setReq(int'(LOCAL), int'(EAST));
        tick();
        i_req = '0;
        setReq(int'(NORTH), int'(EAST));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clearInputs();
        nChecks++;
        if ({o_ack, o_xbar_valid, o_xbar_sel} !== {5'b0, 5'b0, 15'b0})
            $display("[TB] FAIL reset_mid: got ack=%b valid=%b sel=%h want all zero", o_ack, o_xbar_valid, o_xbar_sel);
        else nPass++;
        setReq(int'(NORTH), int'(SOUTH));
        setReq(int'(WEST), int'(SOUTH));
        tick();
        nChecks++;
        if (o_ack !== 5'b00010) $display("[TB] FAIL reset_fresh_grant: got %b want %b", o_ack, 5'b00010);
        else nPass++;
        clearInputs();
    endtask

    // Agents: 0 idle, 1 requesting (holds until acked), 2 owning (counts down to done).
    task automatic test_random();
        int aState [NP];
        int aTimer [NP];
        bit didReset;
        doReset();
        for (int i = 0; i < NP; i++) begin
            aState[i] = 0;
            aTimer[i] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            i_packet_done = '0;
            for (int i = 0; i < NP; i++) begin
                case (aState[i])
                    0: begin
                        i_req[i] = 1'b0;
                        if ($urandom_range(0, 99) < 30) begin
                            setReq(i, $urandom_range(0, 4));
                            aState[i] = 1;
                        end else if ($urandom_range(0, 99) < 10) begin
                            setReq(i, $urandom_range(5, 7));
                        end
                        if (aState[i] == 0 && $urandom_range(0, 99) < 5) i_packet_done[i] = 1'b1;
                    end
                    1: begin
                        if ($urandom_range(0, 99) < 3) begin
                            i_req[i]  = 1'b0;
                            aState[i] = 0;
                        end
                    end
                    default: begin
                        if (aTimer[i] == 0) begin
                            i_packet_done[i] = 1'b1;
                            aState[i] = 0;
                        end else begin
                            aTimer[i]--;
                        end
                    end
                endcase
            end
            didReset = ($urandom_range(0, 99) < 1);
            reset    = didReset;
            tick();
            reset = 1'b0;
            nChecks++;
            if (o_ack !== mAck) $display("[TB] FAIL rand_ack@%0d: got %b want %b", cyc, o_ack, mAck);
            else nPass++;
            nChecks++;
            if (o_xbar_valid !== expValid()) $display("[TB] FAIL rand_valid@%0d: got %b want %b", cyc, o_xbar_valid, expValid());
            else nPass++;
            nChecks++;
            if (o_xbar_sel !== expSel()) $display("[TB] FAIL rand_sel@%0d: got %h want %h", cyc, o_xbar_sel, expSel());
            else nPass++;
            for (int i = 0; i < NP; i++) begin
                if (didReset) begin
                    aState[i] = 0;
                    i_req[i]  = 1'b0;
                end else if (mAck[i] && aState[i] == 1) begin
                    aState[i] = 2;
                    aTimer[i] = $urandom_range(0, 5);
                    i_req[i]  = 1'b0;
                end
            end
        end
        clearInputs();
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_single();
        test_contention();
        test_lock_hold_wrap();
        test_parallel_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
